// File: rtl/lighting_controller_if.sv
// Sensor, override and lamp-status bundle for lighting_controller.
// master drives the sensors/overrides; slave is the controller itself.
interface lighting_controller_if;
  logic       motion;
  logic       dark;
  logic       manual_on;
  logic       manual_off;
  logic [1:0] present_state;
  logic       light;
  logic       dim;
  logic [7:0] on_count;

  modport master (
    output motion, dark, manual_on, manual_off,
    input  present_state, light, dim, on_count
  );

  modport slave (
    input  motion, dark, manual_on, manual_off,
    output present_state, light, dim, on_count
  );
endinterface

// File: rtl/lighting_controller.sv
// Occupancy lighting FSM: OFF/ON/HOLD/DIM with hold/dim timeouts.
// Ports: clk, rst_n (async low), io (slave: sensors in, lamp state out).
module lighting_controller #(
  parameter int HOLD_CYCLES = 1000,
  parameter int DIM_CYCLES  = 250,
  parameter int TIMER_W     = 16
) (
  input logic              clk,
  input logic              rst_n,
  lighting_controller_if.slave io
);

  typedef enum logic [1:0] {
    OFF  = 2'b00,
    ON   = 2'b01,
    HOLD = 2'b10,
    DIM  = 2'b11
  } state_t;

  localparam logic [TIMER_W-1:0] HOLD_LD =
    TIMER_W'(HOLD_CYCLES - 1);
  localparam logic [TIMER_W-1:0] DIM_LD =
    TIMER_W'(DIM_CYCLES - 1);

  state_t             state, nxt;
  logic [TIMER_W-1:0] timer, tmr_nxt;
  logic [1:0]         m_sync, d_sync;
  logic [1:0]         rst_q;
  logic               ms, ds, run;

  assign ms  = m_sync[1];
  assign ds  = d_sync[1];
  // FSM runs only once the release of rst_n has crossed two flops
  assign run = rst_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_q  <= 2'b00;
      m_sync <= 2'b00;
      d_sync <= 2'b00;
    end else begin
      rst_q  <= {rst_q[0], 1'b1};
      m_sync <= {m_sync[0], io.motion};
      d_sync <= {d_sync[0], io.dark};
    end
  end

  always_comb begin
    nxt     = state;
    tmr_nxt = timer;
    unique case (1'b1)
      io.manual_off: begin
        nxt     = OFF;
        tmr_nxt = '0;
      end
      (!io.manual_off && io.manual_on): begin
        nxt = ON;
      end
      default: begin
        unique case (state)
          OFF: begin
            if (ms && ds) nxt = ON;
          end
          ON: begin
            if (!ms) begin
              nxt     = HOLD;
              tmr_nxt = HOLD_LD;
            end
          end
          HOLD: begin
            if (ms) begin
              nxt = ON;
            end else if (timer == '0) begin
              nxt     = DIM;
              tmr_nxt = DIM_LD;
            end else begin
              tmr_nxt = timer - 1'b1;
            end
          end
          DIM: begin
            if (ms) begin
              nxt = ON;
            end else if (timer == '0) begin
              nxt = OFF;
            end else begin
              tmr_nxt = timer - 1'b1;
            end
          end
        endcase
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= OFF;
      timer       <= '0;
      io.light    <= 1'b0;
      io.dim      <= 1'b0;
      io.on_count <= 8'd0;
    end else if (run) begin
      state    <= nxt;
      timer    <= tmr_nxt;
      io.light <= (nxt != OFF);
      io.dim   <= (nxt == DIM);
      if (state == OFF && nxt == ON &&
          io.on_count != 8'hFF)
        io.on_count <= io.on_count + 8'd1;
    end
  end

  assign io.present_state = state;

endmodule

// File: doc/lighting_controller.md
LIGHTING_CONTROLLER -- requirements
Module: lighting_controller

Interface
REQ-001 Parameter HOLD_CYCLES, default 1000: full-brightness hold time after motion ends, in clocks; legal range 1..2^TIMER_W-1.
REQ-002 Parameter DIM_CYCLES, default 250: dimmed time before lights off, in clocks; legal range 1..2^TIMER_W-1.
REQ-003 Parameter TIMER_W, default 16: timeout counter width.
REQ-004 Clock  input  1  single clock; all state changes on the rising edge.
REQ-005 Reset_n  input  1  asynchronous, active-low reset.
REQ-006 Motion  input  1  occupancy sensor; asynchronous to Clock.
REQ-007 Dark  input  1  ambient-light sensor, 1 = dark; asynchronous to Clock.
REQ-008 Manual_On  input  1  override, level-sensitive; synchronous to Clock.
REQ-009 Manual_Off  input  1  override, level-sensitive; synchronous to Clock.
REQ-010 Present_State  output  2  registered FSM state; drives the existing lamp output decode (lamp lit when state is nonzero).
REQ-011 Light  output  1  registered; 1 when Present_State != 00.
REQ-012 Dim  output  1  registered; 1 when Present_State == 11.
REQ-013 On_Count  output  8  registered count of OFF-to-ON transitions, saturating.

Function
REQ-014 State encoding SHALL be OFF=00, ON=01, HOLD=10, DIM=11.
REQ-015 Motion and Dark SHALL each pass through a 2-flop synchronizer; Motion_s and Dark_s denote the second-stage outputs.
REQ-016 Latency SHALL be as follows: an input change sampled at edge N appears at Motion_s after edge N+1, and the resulting state change appears on Present_State after edge N+2.
REQ-017 Manual inputs SHALL NOT be synchronized; the state change appears on the edge after they are sampled.
REQ-018 Priority per cycle SHALL be Manual_Off > Manual_On > Motion_s > timer expiry.
REQ-019 Manual_Off=1 SHALL force the next state to OFF from any state and clear the timer.
REQ-020 Manual_On=1 with Manual_Off=0 SHALL force the next state to ON from any state, regardless of Dark_s.
REQ-021 Transition OFF: to ON when Motion_s=1 and Dark_s=1; otherwise remain OFF.
REQ-022 Transition ON: while Motion_s=1 or Manual_On=1, remain ON; else go to HOLD and load timer = HOLD_CYCLES-1.
REQ-023 Transition HOLD: Motion_s=1 returns to ON; else if timer==0, go to DIM and load timer = DIM_CYCLES-1; else decrement timer.
REQ-024 Transition DIM: Motion_s=1 returns to ON (Dark_s not required); else if timer==0, go to OFF; else decrement timer.
REQ-025 With no motion, the block SHALL spend exactly HOLD_CYCLES cycles in HOLD, then exactly DIM_CYCLES cycles in DIM.
REQ-026 Returning to ON from HOLD or DIM SHALL NOT increment On_Count.
REQ-027 The timer SHALL hold its value in OFF and ON and SHALL never underflow.
REQ-028 On_Count SHALL increment by 1 on each OFF-to-ON edge, whether from motion or Manual_On.
REQ-029 On_Count SHALL saturate at 255.
REQ-030 Light and Dim SHALL be decoded from the next state and registered, so they change on the same edge as Present_State.
REQ-031 Manual_On and Manual_Off asserted together SHALL resolve to OFF.

Reset
REQ-032 Reset_n=0 SHALL immediately force Present_State=00, Light=0, Dim=0, On_Count=0, timer=0 and both synchronizers to 0, without waiting for a clock edge.
REQ-033 Reset_n deassertion SHALL be synchronized internally; the first state update occurs no earlier than the second rising edge after deassertion.
REQ-034 Reset asserted mid-HOLD or mid-DIM SHALL abort the timeout; after release the block SHALL start in OFF.

Verification
REQ-035 Scenario (HOLD_CYCLES=4, DIM_CYCLES=2): Dark=1, Motion 0->1 at edge N -> Present_State=01, Light=1, On_Count=1 after edge N+2.
REQ-036 Scenario: in ON, Motion falls -> 01->10 two edges later; 4 cycles in 10 with Dim=0, then 2 cycles in 11 with Dim=1, then 00 with Light=0.
REQ-037 Scenario: Dark=0, Motion=1 held 20 cycles -> state stays 00 and On_Count stays 0; Manual_On=1 for 1 cycle -> 01, On_Count=1.
REQ-038 Scenario: Motion re-asserts in DIM on its 1st cycle -> returns to 01; On_Count unchanged; a later timeout restarts HOLD from 4.
REQ-039 Scenario: Manual_On=1 and Manual_Off=1 in state ON -> 00 next edge; Reset_n pulsed low mid-HOLD -> outputs 0 asynchronously, On_Count=0.
REQ-040 Scenario: 300 OFF-to-ON cycles -> On_Count=255, with no wrap.
